// File: rtl/reg_read_port_pkg.sv
// Shared defaults and buffer-count type for the register-file read port.
package reg_read_port_pkg;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_NREG   = 16;

   typedef logic [1:0] cnt_t;
   localparam cnt_t CNT_EMPTY = 2'd0;
   localparam cnt_t CNT_FULL  = 2'd2;

   function automatic cnt_t next_count(input cnt_t c, input logic push, input logic pop);
      return c + cnt_t'(push) - cnt_t'(pop);
   endfunction
endpackage

// File: rtl/reg_read_port_if.sv
// Request, register-file and response signals of the read port, seen from both ends.
interface reg_read_port_if
   import reg_read_port_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   // valid/ready: a transfer happens at a rising edge where both are high; the
   // valid side holds its payload until taken (rsp_data may still take a snoop update).
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] rsp_addr;
   logic              rsp_err;

   modport slave (
      input  req_valid, req_addr, rd_data, wr_en, wr_addr, wr_data, rsp_ready,
      output req_ready, rd_addr, rsp_valid, rsp_data, rsp_addr, rsp_err
   );

   modport master (
      output req_valid, req_addr, rd_data, wr_en, wr_addr, wr_data, rsp_ready,
      input  req_ready, rd_addr, rsp_valid, rsp_data, rsp_addr, rsp_err
   );
endinterface

// File: rtl/reg_read_port_rsp_fifo2.sv
// Two-entry response FIFO; every valid in-range entry tracks writes to its address.
module reg_read_port_rsp_fifo2
   import reg_read_port_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [ADDR_W-1:0] i_push_addr,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_push_err,
   input  logic              i_pop,
   input  logic              i_snoop_en,
   input  logic [ADDR_W-1:0] i_snoop_addr,
   input  logic [DATA_W-1:0] i_snoop_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_err,
   output cnt_t              o_count
);
   logic [DATA_W-1:0] r_data [2];
   logic [ADDR_W-1:0] r_addr [2];
   logic              r_err  [2];
   cnt_t              r_count;

   logic [DATA_W-1:0] w_data_s [2];
   logic [DATA_W-1:0] w_data_n [2];
   logic [ADDR_W-1:0] w_addr_n [2];
   logic              w_err_n  [2];
   logic              w_pop;
   logic              w_push;
   logic              w_hit0;
   logic              w_hit1;
   cnt_t              w_wr_idx;

   always_comb begin
      w_pop    = i_pop && (r_count != CNT_EMPTY);
      w_push   = i_push && (r_count != CNT_FULL);
      w_hit0   = i_snoop_en && (r_count != CNT_EMPTY) && !r_err[0] && (r_addr[0] == i_snoop_addr);
      w_hit1   = i_snoop_en && (r_count == CNT_FULL) && !r_err[1] && (r_addr[1] == i_snoop_addr);
      w_data_s[0] = w_hit0 ? i_snoop_data : r_data[0];
      w_data_s[1] = w_hit1 ? i_snoop_data : r_data[1];
      w_data_n = w_data_s;
      w_addr_n = r_addr;
      w_err_n  = r_err;
      // The head leaves with its registered data; only the survivor takes the snoop.
      if (w_pop) begin
         w_data_n[0] = w_data_s[1];
         w_addr_n[0] = r_addr[1];
         w_err_n[0]  = r_err[1];
      end
      w_wr_idx = r_count - cnt_t'(w_pop);
      if (w_push) begin
         if (w_wr_idx == CNT_EMPTY) begin
            w_data_n[0] = i_push_data;
            w_addr_n[0] = i_push_addr;
            w_err_n[0]  = i_push_err;
         end else begin
            w_data_n[1] = i_push_data;
            w_addr_n[1] = i_push_addr;
            w_err_n[1]  = i_push_err;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= CNT_EMPTY;
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= '0;
            r_addr[i] <= '0;
            r_err[i]  <= 1'b0;
         end
      end else begin
         r_count <= next_count(r_count, w_push, w_pop);
         r_data  <= w_data_n;
         r_addr  <= w_addr_n;
         r_err   <= w_err_n;
      end
   end

   assign o_valid = (r_count != CNT_EMPTY);
   assign o_data  = r_data[0];
   assign o_addr  = r_addr[0];
   assign o_err   = r_err[0];
   assign o_count = r_count;
endmodule

// File: rtl/reg_read_port.sv
// Read port for the register file: accepts requests, samples/forwards data, buffers responses.
module reg_read_port
   import reg_read_port_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NREG   = DEF_NREG
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   reg_read_port_if.slave io_bus,
   output cnt_t           o_dbg_count
);
   localparam logic [ADDR_W:0] NREG_C = (ADDR_W + 1)'(NREG);

   logic              w_req_ready;
   logic              w_push;
   logic              w_err;
   logic              w_fwd;
   logic [DATA_W-1:0] w_push_data;
   logic              w_head_valid;
   logic [DATA_W-1:0] w_head_data;
   logic [ADDR_W-1:0] w_head_addr;
   logic              w_head_err;
   cnt_t              w_count;

   // Ready depends only on the registered count so no path runs from rsp_ready.
   assign w_req_ready = (w_count != CNT_FULL);
   assign w_push      = io_bus.req_valid && w_req_ready;
   assign w_err       = ({1'b0, io_bus.req_addr} >= NREG_C);
   assign w_fwd       = io_bus.wr_en && (io_bus.wr_addr == io_bus.req_addr);
   assign w_push_data = w_err ? '0 : (w_fwd ? io_bus.wr_data : io_bus.rd_data);

   reg_read_port_rsp_fifo2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_push       (w_push),
      .i_push_addr  (io_bus.req_addr),
      .i_push_data  (w_push_data),
      .i_push_err   (w_err),
      .i_pop        (io_bus.rsp_ready),
      .i_snoop_en   (io_bus.wr_en),
      .i_snoop_addr (io_bus.wr_addr),
      .i_snoop_data (io_bus.wr_data),
      .o_valid      (w_head_valid),
      .o_data       (w_head_data),
      .o_addr       (w_head_addr),
      .o_err        (w_head_err),
      .o_count      (w_count)
   );

   assign io_bus.rd_addr   = io_bus.req_addr;
   assign io_bus.req_ready = w_req_ready;
   assign io_bus.rsp_valid = w_head_valid;
   assign io_bus.rsp_data  = w_head_valid ? w_head_data : '0;
   assign io_bus.rsp_addr  = w_head_valid ? w_head_addr : '0;
   assign io_bus.rsp_err   = w_head_valid && w_head_err;
   assign o_dbg_count      = w_count;
endmodule

// File: tb/tb_reg_read_port.sv
// Directed bench for reg_read_port with a behavioural register file committing on the falling edge.
module tb_reg_read_port;
   import reg_read_port_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   cnt_t dbg_count;
   int   total = 0;
   int   bad = 0;
   logic [15:0] regs [16];

   always #5 clk = ~clk;

   reg_read_port_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   reg_read_port #(.DATA_W(16), .ADDR_W(4), .NREG(12)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .io_bus      (bus),
      .o_dbg_count (dbg_count)
   );

   // Register file model: combinational read, write commits on the falling edge.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
      end else if (bus.wr_en) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end
   assign bus.rd_data = regs[bus.rd_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
      chk({tag, "_data"}, {16'd0, bus.rsp_data}, 32'd0);
      chk({tag, "_addr"}, {28'd0, bus.rsp_addr}, 32'd0);
      chk({tag, "_err"}, {31'd0, bus.rsp_err}, 32'd0);
   endtask

   task automatic req(input logic [3:0] a);
      bus.req_valid = 1'b1; bus.req_addr = a;
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_addr = 4'd0; bus.rsp_ready = 1'b0;
      bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 16'h0000;
      #3;
      chk_empty("rst0");
      chk("rst0_req_ready", {31'd0, bus.req_ready}, 32'd1);
      @(negedge clk); #1;
      rst_n = 1'b1;
      tick();

      write_reg(4'd3, 16'h1234);
      write_reg(4'd1, 16'h0011);
      write_reg(4'd2, 16'h0022);
      write_reg(4'd4, 16'h0044);
      write_reg(4'd7, 16'h0007);
      write_reg(4'd14, 16'h5555);

      // Single read
      bus.rsp_ready = 1'b1;
      req(4'd3);
      chk("rd_addr_comb", {28'd0, bus.rd_addr}, 32'd3);
      tick();
      bus.req_valid = 1'b0;
      chk("single_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("single_data", {16'd0, bus.rsp_data}, 32'h1234);
      chk("single_addr", {28'd0, bus.rsp_addr}, 32'd3);
      chk("single_err", {31'd0, bus.rsp_err}, 32'd0);
      tick();
      chk_empty("single_after");

      // Backpressure
      bus.rsp_ready = 1'b0;
      req(4'd1);
      tick();
      req(4'd2);
      chk("bp_ready_one", {31'd0, bus.req_ready}, 32'd1);
      tick();
      chk("bp_ready_full", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_count_full", {30'd0, dbg_count}, 32'd2);
      req(4'd4);
      tick();
      chk("bp_ready_held", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_head_hold_data", {16'd0, bus.rsp_data}, 32'h0011);
      chk("bp_head_hold_addr", {28'd0, bus.rsp_addr}, 32'd1);
      bus.rsp_ready = 1'b1;
      tick();
      chk("bp_second_data", {16'd0, bus.rsp_data}, 32'h0022);
      chk("bp_second_ready", {31'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 1'b0;
      chk("bp_third_data", {16'd0, bus.rsp_data}, 32'h0044);
      chk("bp_third_addr", {28'd0, bus.rsp_addr}, 32'd4);
      chk("bp_third_count", {30'd0, dbg_count}, 32'd1);
      tick();
      chk_empty("bp_drained");

      // Forwarding of a same-edge write
      req(4'd5);
      bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
      tick();
      bus.req_valid = 1'b0; bus.wr_en = 1'b0;
      chk("fwd_data", {16'd0, bus.rsp_data}, 32'hBEEF);
      chk("fwd_addr", {28'd0, bus.rsp_addr}, 32'd5);
      tick();
      chk_empty("fwd_after");

      // Snoop update of a buffered entry
      bus.rsp_ready = 1'b0;
      req(4'd7);
      tick();
      bus.req_valid = 1'b0;
      chk("snoop_pre", {16'd0, bus.rsp_data}, 32'h0007);
      write_reg(4'd7, 16'hA5A5);
      chk("snoop_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("snoop_data", {16'd0, bus.rsp_data}, 32'hA5A5);
      write_reg(4'd7, 16'h0007);
      chk("snoop_back", {16'd0, bus.rsp_data}, 32'h0007);
      req(4'd7);
      tick();
      bus.req_valid = 1'b0;
      chk("snoop_two_count", {30'd0, dbg_count}, 32'd2);
      bus.rsp_ready = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'hA5A5;
      #1;
      chk("snoop_pop_value", {16'd0, bus.rsp_data}, 32'h0007);
      tick();
      bus.wr_en = 1'b0;
      chk("snoop_survivor_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("snoop_survivor_data", {16'd0, bus.rsp_data}, 32'hA5A5);
      chk("snoop_survivor_count", {30'd0, dbg_count}, 32'd1);
      tick();
      chk_empty("snoop_drained");

      // Out-of-range address
      bus.rsp_ready = 1'b0;
      req(4'd14);
      tick();
      bus.req_valid = 1'b0;
      chk("range_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("range_err", {31'd0, bus.rsp_err}, 32'd1);
      chk("range_data", {16'd0, bus.rsp_data}, 32'd0);
      chk("range_addr", {28'd0, bus.rsp_addr}, 32'd14);
      write_reg(4'd14, 16'h7777);
      chk("range_nosnoop_data", {16'd0, bus.rsp_data}, 32'd0);
      chk("range_nosnoop_err", {31'd0, bus.rsp_err}, 32'd1);
      bus.rsp_ready = 1'b1;
      tick();
      chk_empty("range_drained");

      // Asynchronous reset with two entries buffered
      bus.rsp_ready = 1'b0;
      req(4'd1);
      tick();
      req(4'd2);
      tick();
      bus.req_valid = 1'b0;
      chk("mid_count", {30'd0, dbg_count}, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("mid_rst_data", {16'd0, bus.rsp_data}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk_empty("post_rst");
      chk("post_rst_count", {30'd0, dbg_count}, 32'd0);
      chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
